// File: rtl/cnt3_event_tracker.sv
// cnt3_event_tracker: classifies {c,b,a} counter transitions into a small event FIFO.
// Optional timestamping with CNT3_TRACK_STAMP_EN.
module cnt3_event_tracker #(
  parameter int DEPTH  = 4,
  parameter int WRAP_W = 8
`ifdef CNT3_TRACK_STAMP_EN
  , parameter int STAMP_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cnt,
  input  logic              clr,
  input  logic              ev_ready,
  output logic              ev_valid,
  output logic [1:0]        ev_code,
  output logic [2:0]        ev_cnt,
`ifdef CNT3_TRACK_STAMP_EN
  output logic [STAMP_W-1:0] ev_stamp,
`endif
  output logic [WRAP_W-1:0] wraps,
  output logic              err,
  output logic              ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {PRIME, TRACK, FAULT} state_t;

  state_t          state;
  logic [2:0]      prev;
  logic [1:0]      code_mem [DEPTH];
  logic [2:0]      cnt_mem  [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic [1:0]      last_code;
  logic [2:0]      last_cnt;

  logic            hold;
  logic            is_wrap;
  logic            is_inc;
  logic            is_round;
  logic [1:0]      code;
  logic            push;
  logic            pop;
  logic            full;
  logic            wr_en;

  assign ev_valid = (count != '0);
  assign full     = (count == FULL_N);
  // Head is shown while non-empty; otherwise the last shown value is held.
  assign ev_code  = ev_valid ? code_mem[rptr] : last_code;
  assign ev_cnt   = ev_valid ? cnt_mem[rptr]  : last_cnt;

  always_comb begin
    hold     = (cnt == prev);
    is_wrap  = (prev == 3'd7) && (cnt == 3'd0);
    is_inc   = (cnt == prev + 3'd1);
    is_round = (cnt == {prev[2], 2'b00}) && (prev[1:0] != 2'b00);
    code     = 2'b11;
    priority case (1'b1)
      is_wrap:  code = 2'b01;
      is_inc:   code = 2'b00;
      is_round: code = 2'b10;
      default:  code = 2'b11;
    endcase
  end

  assign push  = (state == TRACK) && !hold && !clr;
  assign pop   = ev_valid && ev_ready && !clr;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      code_mem[wptr] <= code;
      cnt_mem[wptr]  <= cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRIME;
      prev      <= 3'd0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      last_code <= 2'b00;
      last_cnt  <= 3'd0;
      wraps     <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      state     <= PRIME;
      prev      <= cnt;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      last_code <= ev_code;
      last_cnt  <= ev_cnt;
      wraps     <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      prev      <= cnt;
      last_code <= ev_code;
      last_cnt  <= ev_cnt;
      unique case (state)
        PRIME: state <= TRACK;
        TRACK: begin
          if (!hold && code == 2'b11) begin
            state <= FAULT;
            err   <= 1'b1;
          end
        end
        FAULT: state <= FAULT;
        default: state <= PRIME;
      endcase
      if (push && is_wrap && wraps != '1)
        wraps <= wraps + 1'b1;
      if (push && full && !pop)
        ovf <= 1'b1;
      if (wr_en)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef CNT3_TRACK_STAMP_EN
  logic [STAMP_W-1:0] stamp;
  logic [STAMP_W-1:0] stamp_mem [DEPTH];
  logic [STAMP_W-1:0] last_stamp;

  assign ev_stamp = ev_valid ? stamp_mem[rptr] : last_stamp;

  always_ff @(posedge clk) begin
    if (wr_en)
      stamp_mem[wptr] <= stamp;
  end

  // Free-running; deliberately not cleared by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp      <= '0;
      last_stamp <= '0;
    end else begin
      stamp      <= stamp + 1'b1;
      last_stamp <= ev_stamp;
    end
  end
`endif

endmodule

// File: tb/tb_cnt3_event_tracker.sv
// Directed bench for cnt3_event_tracker; expected values hand-computed.
// Stamp checks run only when CNT3_TRACK_STAMP_EN is defined.
module tb_cnt3_event_tracker;

  logic       clk;
  logic       rst_n;
  logic [2:0] cnt;
  logic       clr;
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic [2:0] ev_cnt;
  logic [7:0] wraps;
  logic       err;
  logic       ovf;
`ifdef CNT3_TRACK_STAMP_EN
  logic [15:0] ev_stamp;
`endif

  int total;
  int bad;

  cnt3_event_tracker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .clr      (clr),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_cnt   (ev_cnt),
`ifdef CNT3_TRACK_STAMP_EN
    .ev_stamp (ev_stamp),
`endif
    .wraps    (wraps),
    .err      (err),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [2:0] c, input logic r);
    cnt      = c;
    ev_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input int v, input int code, input int c);
    chk({tag, ".valid"}, int'(ev_valid), v);
    chk({tag, ".code"}, int'(ev_code), code);
    chk({tag, ".cnt"}, int'(ev_cnt), c);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    cnt      = 3'd0;
    clr      = 1'b0;
    ev_ready = 1'b0;
    #12;
    head("rst", 0, 0, 0);
    chk("rst.wraps", int'(wraps), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.ovf", int'(ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // count 0..7 then wrap, consumer always ready
    tick(3'd0, 1'b1);
    chk("prime.valid", int'(ev_valid), 0);
    for (int i = 1; i < 8; i++) begin
      tick(3'(i), 1'b1);
      head("inc", 1, 0, i);
    end
    tick(3'd0, 1'b1);
    head("wrap", 1, 1, 0);
    chk("wrap.wraps", int'(wraps), 1);
    chk("wrap.err", int'(err), 0);
    tick(3'd0, 1'b1);
    head("hold_empty", 0, 1, 0);

    // round clears
    tick(3'd1, 1'b1);
    tick(3'd2, 1'b1);
    tick(3'd3, 1'b1);
    tick(3'd0, 1'b1);
    head("round30", 1, 2, 0);
    for (int i = 1; i < 6; i++) tick(3'(i), 1'b1);
    tick(3'd4, 1'b1);
    head("round54", 1, 2, 4);
    tick(3'd4, 1'b1);
    chk("hold44.valid", int'(ev_valid), 0);

    // illegal jump into FAULT
    tick(3'd5, 1'b1);
    tick(3'd6, 1'b1);
    tick(3'd7, 1'b1);
    tick(3'd0, 1'b1);
    chk("wrap2.wraps", int'(wraps), 2);
    tick(3'd1, 1'b1);
    tick(3'd2, 1'b1);
    tick(3'd6, 1'b1);
    head("illegal", 1, 3, 6);
    chk("illegal.err", int'(err), 1);
    tick(3'd7, 1'b1);
    chk("fault.valid", int'(ev_valid), 0);
    tick(3'd0, 1'b1);
    chk("fault.valid2", int'(ev_valid), 0);
    chk("fault.wraps", int'(wraps), 2);
    clr = 1'b1;
    tick(3'd0, 1'b0);
    clr = 1'b0;
    chk("clr.err", int'(err), 0);
    chk("clr.wraps", int'(wraps), 0);
    chk("clr.valid", int'(ev_valid), 0);
    tick(3'd0, 1'b0);
    chk("clr.prime", int'(ev_valid), 0);

    // overflow: five pushes into four entries
    for (int i = 1; i < 5; i++) tick(3'(i), 1'b0);
    head("full", 1, 0, 1);
    chk("full.ovf", int'(ovf), 0);
    tick(3'd5, 1'b0);
    chk("drop.ovf", int'(ovf), 1);
    chk("drop.head", int'(ev_cnt), 1);
    for (int i = 2; i < 5; i++) begin
      tick(3'd5, 1'b1);
      head("drain", 1, 0, i);
    end
    tick(3'd5, 1'b1);
    head("drained", 0, 0, 4);

    // full FIFO with simultaneous push and pop
    clr = 1'b1;
    tick(3'd5, 1'b0);
    clr = 1'b0;
    chk("clr2.ovf", int'(ovf), 0);
    tick(3'd5, 1'b0);
    tick(3'd6, 1'b0);
    tick(3'd7, 1'b0);
    tick(3'd0, 1'b0);
    tick(3'd1, 1'b0);
    head("full2", 1, 0, 6);
    tick(3'd2, 1'b1);
    head("pushpop", 1, 0, 7);
    chk("pushpop.ovf", int'(ovf), 0);
    chk("pushpop.wraps", int'(wraps), 1);
    tick(3'd2, 1'b1);
    head("pp.d0", 1, 1, 0);
    tick(3'd2, 1'b1);
    head("pp.d1", 1, 0, 1);
    tick(3'd2, 1'b1);
    head("pp.d2", 1, 0, 2);
    tick(3'd2, 1'b1);
    chk("pp.empty", int'(ev_valid), 0);
    chk("pp.ovf", int'(ovf), 0);

    // mid-run asynchronous reset with entries queued
    tick(3'd3, 1'b0);
    tick(3'd4, 1'b0);
    tick(3'd0, 1'b0);
    chk("pre.err", int'(err), 1);
    chk("pre.valid", int'(ev_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    head("arst", 0, 0, 0);
    chk("arst.wraps", int'(wraps), 0);
    chk("arst.err", int'(err), 0);
    chk("arst.ovf", int'(ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(3'd0, 1'b1);
    chk("arst.prime", int'(ev_valid), 0);

`ifdef CNT3_TRACK_STAMP_EN
    // stamp counter: edge k after reset stores stamp k-1
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick(3'd0, 1'b0);
    tick(3'd1, 1'b0);
    tick(3'd1, 1'b0);
    tick(3'd2, 1'b0);
    chk("stamp0", int'(ev_stamp), 10);
    tick(3'd2, 1'b1);
    chk("stamp1", int'(ev_stamp), 12);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
